// File: rtl/laser_packet_assembler.sv
// Frames laser-receiver beats into packets by header, buffers payload beats in a FIFO, and strobes pkt_done per packet.
// Define LASER_PKT_CHECKSUM_EN to treat the last beat of multi-beat packets as an XOR checksum instead of payload.
module laser_packet_assembler #(
   parameter int          FIFO_DEPTH  = 16,
   parameter logic [11:0] TIMEOUT     = 12'd400,
   parameter logic [9:0]  START_BEATS = 10'd256,
   parameter logic [9:0]  STOP_BEATS  = 10'd3,
   parameter logic [9:0]  ACK_BEATS   = 10'd2,
   parameter logic [9:0]  DONE_BEATS  = 10'd1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data1,
   input  logic [7:0]  rx_data2,
   output logic [15:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        pkt_done,
   output logic [2:0]  pkt_type,
   output logic        pkt_ok,
   output logic        pkt_timeout,
   output logic        pkt_overflow,
   output logic        busy
);
   // state     | meaning
   // S_IDLE    | waiting for a header beat
   // S_PAYLOAD | counting/pushing payload beats, watching inter-beat timeout
   // S_DISCARD | bad header seen; drop beats until the line goes quiet
   // S_REPORT  | one-cycle pkt_done; an rx_valid here is handled as in S_IDLE
   typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DISCARD, S_REPORT} state_t;

   localparam int AW = $clog2(FIFO_DEPTH);

   state_t      state_q, state_d;
   logic [9:0]  remaining_q, remaining_d;
   logic [11:0] idle_q, idle_d, idle_inc;
   logic [2:0]  cur_type_q, cur_type_d;
   logic        ovf_q, ovf_d, ovf_now;
   logic        pkt_done_q, pkt_done_d;
   logic [2:0]  pkt_type_q, pkt_type_d;
   logic        pkt_ok_q, pkt_ok_d;
   logic        pkt_timeout_q, pkt_timeout_d;
   logic        pkt_overflow_q, pkt_overflow_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [15:0] mem_q [FIFO_DEPTH];
`ifdef LASER_PKT_CHECKSUM_EN
   logic [15:0] csum_q, csum_d;
`endif

   logic        hdr_ok, timeout_hit, push, push_ok, pop, full, fifo_blocked;
   logic [2:0]  hdr_type;
   logic [9:0]  hdr_len;
   logic [15:0] beat;

   assign beat = {rx_data2, rx_data1};

   always_comb begin
      hdr_ok   = 1'b1;
      hdr_type = 3'd0;
      hdr_len  = 10'd0;
      case (rx_data1)
         8'hcc:   begin hdr_type = 3'd1; hdr_len = START_BEATS; end
         8'h55:   begin hdr_type = 3'd2; hdr_len = STOP_BEATS;  end
         8'h11:   begin hdr_type = 3'd3; hdr_len = ACK_BEATS;   end
         8'hbb:   begin hdr_type = 3'd4; hdr_len = ACK_BEATS;   end
         8'haa:   begin hdr_type = 3'd5; hdr_len = DONE_BEATS;  end
         default: hdr_ok = 1'b0;
      endcase
      if (rx_data2 != ~rx_data1) hdr_ok = 1'b0;
   end

   assign out_valid    = (wr_ptr_q != rd_ptr_q);
   assign out_data     = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : 16'h0000;
   assign full         = ((wr_ptr_q - rd_ptr_q) == (AW+1)'(FIFO_DEPTH));
   assign pop          = out_valid & out_ready;
   // a full FIFO still takes the beat if the consumer frees a slot this cycle
   assign fifo_blocked = full & ~pop;
   assign push_ok      = push & ~fifo_blocked;
   assign wr_ptr_d     = wr_ptr_q + (push_ok ? (AW+1)'(1) : '0);
   assign rd_ptr_d     = rd_ptr_q + (pop ? (AW+1)'(1) : '0);

   assign idle_inc    = (idle_q >= TIMEOUT) ? TIMEOUT : idle_q + 12'd1;
   assign timeout_hit = ~rx_valid & (idle_inc == TIMEOUT);

   always_comb begin
      state_d        = state_q;
      remaining_d    = remaining_q;
      idle_d         = rx_valid ? 12'd0 : idle_inc;
      cur_type_d     = cur_type_q;
      ovf_d          = ovf_q;
      ovf_now        = ovf_q | fifo_blocked;
      pkt_done_d     = 1'b0;
      pkt_type_d     = pkt_type_q;
      pkt_ok_d       = pkt_ok_q;
      pkt_timeout_d  = pkt_timeout_q;
      pkt_overflow_d = pkt_overflow_q;
      push           = 1'b0;
`ifdef LASER_PKT_CHECKSUM_EN
      csum_d         = csum_q;
`endif
      case (state_q)
         S_IDLE, S_REPORT: begin
            state_d = S_IDLE;
            if (rx_valid) begin
               if (hdr_ok) begin
                  cur_type_d  = hdr_type;
                  ovf_d       = 1'b0;
                  remaining_d = hdr_len - 10'd1;
`ifdef LASER_PKT_CHECKSUM_EN
                  csum_d      = 16'h0000;
`endif
                  if (hdr_len == 10'd1) begin
                     state_d        = S_REPORT;
                     pkt_done_d     = 1'b1;
                     pkt_type_d     = hdr_type;
                     pkt_ok_d       = 1'b1;
                     pkt_timeout_d  = 1'b0;
                     pkt_overflow_d = 1'b0;
                  end else begin
                     state_d = S_PAYLOAD;
                  end
               end else begin
                  state_d = S_DISCARD;
               end
            end
         end
         S_PAYLOAD: begin
            if (rx_valid) begin
               remaining_d = remaining_q - 10'd1;
               if (remaining_q == 10'd1) begin
                  state_d       = S_REPORT;
                  pkt_done_d    = 1'b1;
                  pkt_type_d    = cur_type_q;
                  pkt_timeout_d = 1'b0;
`ifdef LASER_PKT_CHECKSUM_EN
                  pkt_overflow_d = ovf_q;
                  pkt_ok_d       = ~ovf_q & (beat == csum_q);
`else
                  push           = 1'b1;
                  pkt_overflow_d = ovf_now;
                  pkt_ok_d       = ~ovf_now;
`endif
               end else begin
                  push  = 1'b1;
                  ovf_d = ovf_now;
`ifdef LASER_PKT_CHECKSUM_EN
                  csum_d = csum_q ^ beat;
`endif
               end
            end else if (timeout_hit) begin
               state_d        = S_REPORT;
               pkt_done_d     = 1'b1;
               pkt_type_d     = cur_type_q;
               pkt_ok_d       = 1'b0;
               pkt_timeout_d  = 1'b1;
               pkt_overflow_d = ovf_q;
            end
         end
         S_DISCARD: begin
            if (timeout_hit) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d != state_q) idle_d = 12'd0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         remaining_q    <= 10'd0;
         idle_q         <= 12'd0;
         cur_type_q     <= 3'd0;
         ovf_q          <= 1'b0;
         pkt_done_q     <= 1'b0;
         pkt_type_q     <= 3'd0;
         pkt_ok_q       <= 1'b0;
         pkt_timeout_q  <= 1'b0;
         pkt_overflow_q <= 1'b0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
`ifdef LASER_PKT_CHECKSUM_EN
         csum_q         <= 16'h0000;
`endif
      end else begin
         state_q        <= state_d;
         remaining_q    <= remaining_d;
         idle_q         <= idle_d;
         cur_type_q     <= cur_type_d;
         ovf_q          <= ovf_d;
         pkt_done_q     <= pkt_done_d;
         pkt_type_q     <= pkt_type_d;
         pkt_ok_q       <= pkt_ok_d;
         pkt_timeout_q  <= pkt_timeout_d;
         pkt_overflow_q <= pkt_overflow_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
`ifdef LASER_PKT_CHECKSUM_EN
         csum_q         <= csum_d;
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= beat;
   end

   assign pkt_done     = pkt_done_q;
   assign pkt_type     = pkt_type_q;
   assign pkt_ok       = pkt_ok_q;
   assign pkt_timeout  = pkt_timeout_q;
   assign pkt_overflow = pkt_overflow_q;
   assign busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_laser_packet_assembler.sv
// Directed bench for laser_packet_assembler: payload beats and packet reports are checked against scoreboard queues.
module tb_laser_packet_assembler;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data1 = 8'h00, rx_data2 = 8'h00;
   logic [15:0] out_data;
   logic        out_valid, out_ready = 1'b0;
   logic        pkt_done, pkt_ok, pkt_timeout, pkt_overflow, busy;
   logic [2:0]  pkt_type;

   int errors = 0;
   int checks = 0;

   logic [15:0] sb_q[$];
   logic [5:0]  pkt_q[$];  // {type, ok, timeout, overflow}

   laser_packet_assembler dut (
      .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data1(rx_data1), .rx_data2(rx_data2),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .pkt_done(pkt_done), .pkt_type(pkt_type), .pkt_ok(pkt_ok), .pkt_timeout(pkt_timeout),
      .pkt_overflow(pkt_overflow), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] d2, input logic [7:0] d1);
      rx_valid = 1'b1;
      rx_data2 = d2;
      rx_data1 = d1;
      @(posedge clock);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Output side: a transfer happens at the next rising edge, so sample mid-cycle.
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         if (sb_q.size() == 0) chk("unexpected_beat", {16'h0, out_data}, 32'hffff_ffff);
         else chk("beat", {16'h0, out_data}, {16'h0, sb_q.pop_front()});
      end
      if (!reset && pkt_done) begin
         if (pkt_q.size() == 0) chk("unexpected_pkt_done", {26'h0, pkt_type, pkt_ok, pkt_timeout, pkt_overflow}, 32'hffff_ffff);
         else chk("pkt_report", {26'h0, pkt_type, pkt_ok, pkt_timeout, pkt_overflow}, {26'h0, pkt_q.pop_front()});
      end
   end

   initial begin
      logic [15:0] b, x;
      #2;
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_out_data", {16'h0, out_data}, 32'h0);
      chk("rst_pkt_done", {31'h0, pkt_done}, 32'h0);
      chk("rst_pkt_type", {29'h0, pkt_type}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      idle(2);
      reset = 1'b0;
      idle(2);
      out_ready = 1'b1;

      // DONE: header-only packet, nothing enters the FIFO
      pkt_q.push_back({3'd5, 1'b1, 1'b0, 1'b0});
      send(8'h55, 8'haa);
      idle(3);
      chk("done_fifo_empty", {31'h0, out_valid}, 32'h0);
      chk("done_type_held", {29'h0, pkt_type}, 32'd5);

      // two DONE headers back to back: the one seen during REPORT is not lost
      pkt_q.push_back({3'd5, 1'b1, 1'b0, 1'b0});
      pkt_q.push_back({3'd5, 1'b1, 1'b0, 1'b0});
      send(8'h55, 8'haa);
      send(8'h55, 8'haa);
      idle(3);

      // START: 255 beats streamed out in order
      x = 16'h0000;
      send(8'h33, 8'hcc);
      for (int i = 1; i <= 255; i++) begin
         if (i < 255) begin
            b = {8'(i), 8'(i * 7 + 3)};
            x = x ^ b;
         end else begin
            b = x;
         end
`ifdef LASER_PKT_CHECKSUM_EN
         if (i < 255) sb_q.push_back(b);
`else
         sb_q.push_back(b);
`endif
         if (i == 255) pkt_q.push_back({3'd1, 1'b1, 1'b0, 1'b0});
         send(b[15:8], b[7:0]);
      end
      idle(4);
      chk("start_busy_after", {31'h0, busy}, 32'h0);

      // STOP: one beat then silence -> timeout report
      send(8'haa, 8'h55);
      sb_q.push_back(16'h1234);
      send(8'h12, 8'h34);
      pkt_q.push_back({3'd2, 1'b0, 1'b1, 1'b0});
      idle(100);
      chk("stop_busy_waiting", {31'h0, busy}, 32'h1);
      idle(310);
      chk("stop_busy_after_to", {31'h0, busy}, 32'h0);

      // invalid header -> DISCARD, beats dropped, no report
      send(8'h00, 8'h42);
      for (int i = 0; i < 3; i++) begin
         idle(9);
         send(8'h33, 8'hcc);
      end
      idle(10);
      chk("discard_busy", {31'h0, busy}, 32'h1);
      chk("discard_fifo_empty", {31'h0, out_valid}, 32'h0);
      idle(395);
      chk("discard_busy_after", {31'h0, busy}, 32'h0);

      // ACK / FAIL two-beat packets
      send(8'hee, 8'h11);
`ifdef LASER_PKT_CHECKSUM_EN
      pkt_q.push_back({3'd3, 1'b0, 1'b0, 1'b0});
`else
      sb_q.push_back(16'h3412);
      pkt_q.push_back({3'd3, 1'b1, 1'b0, 1'b0});
`endif
      send(8'h34, 8'h12);
      send(8'hee, 8'h11);
`ifndef LASER_PKT_CHECKSUM_EN
      sb_q.push_back(16'h0000);
`endif
      pkt_q.push_back({3'd3, 1'b1, 1'b0, 1'b0});
      send(8'h00, 8'h00);
      send(8'h44, 8'hbb);
`ifndef LASER_PKT_CHECKSUM_EN
      sb_q.push_back(16'h0000);
`endif
      pkt_q.push_back({3'd4, 1'b1, 1'b0, 1'b0});
      send(8'h00, 8'h00);
      idle(4);

      // START with consumer stalled: 16 beats kept, rest dropped
      out_ready = 1'b0;
      send(8'h33, 8'hcc);
      for (int i = 1; i <= 255; i++) begin
         b = {8'(i + 100), 8'(i)};
         if (i <= 16) sb_q.push_back(b);
         if (i == 255) pkt_q.push_back({3'd1, 1'b0, 1'b0, 1'b1});
         send(b[15:8], b[7:0]);
      end
      idle(2);
      chk("ovf_fifo_full", {31'h0, out_valid}, 32'h1);
      out_ready = 1'b1;
      idle(20);
      chk("ovf_drained", {31'h0, out_valid}, 32'h0);

      // reset mid-packet: FIFO cleared, no report
      out_ready = 1'b0;
      send(8'haa, 8'h55);
      send(8'h01, 8'h02);
      idle(1);
      reset = 1'b1;
      #1;
      chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("midrst_busy", {31'h0, busy}, 32'h0);
      chk("midrst_type", {29'h0, pkt_type}, 32'h0);
      idle(2);
      reset = 1'b0;
      out_ready = 1'b1;
      idle(2);
      pkt_q.push_back({3'd5, 1'b1, 1'b0, 1'b0});
      send(8'h55, 8'haa);
      idle(5);

      chk("sb_empty", sb_q.size(), 32'd0);
      chk("pkt_q_empty", pkt_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
